keypad_scanner: RTL and testbench

Matrix-keypad scanner for the 4x4 hex keypad. It drives one keypad row at a time, senses the four column lines, debounces a press, and reports the hex code of the accepted key. It sits between the keypad pins and the display/history logic. Outputs are one `key_pressed` strobe plus a held `value` per debounced press.

---
 rtl/keypad_pkg.sv | 25 ++
 rtl/keypad_decoder.sv | 38 +++
 rtl/keypad_scanner.sv | 133 +++++++++++++
 tb/tb_keypad_scanner.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
// Holds the FSM state enum, the top-row drive pattern and the key map.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD
    } state_t;

    localparam logic [3:0] ROW_TOP = 4'b1000;

    // Indexed by {row_idx, col_idx}; row_idx 0 is the top row (row[3]), col_idx 0 is columns[0].
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [3:0] rotate_row(input logic [3:0] r);
        return {r[0], r[3:1]};
    endfunction

endpackage

// File: rtl/keypad_decoder.sv
// Combinational key decoder: one-hot row plus column lines (highest column wins)
// to the hex code printed on the key.
module keypad_decoder
    import keypad_pkg::*;
(
    input  logic [3:0] i_row,
    input  logic [3:0] i_columns,
    output logic [3:0] o_value
);

    logic [1:0] w_row_idx;
    logic [1:0] w_col_idx;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_row_idx = 2'd0;
        case (i_row)
            4'b1000: w_row_idx = 2'd0;
            4'b0100: w_row_idx = 2'd1;
            4'b0010: w_row_idx = 2'd2;
            4'b0001: w_row_idx = 2'd3;
            default: w_row_idx = 2'd0;
        endcase
    end

    always_comb begin
        w_col_idx = 2'd0;
        casez (i_columns)
            4'b1???: w_col_idx = 2'd3;
            4'b01??: w_col_idx = 2'd2;
            4'b001?: w_col_idx = 2'd1;
            default: w_col_idx = 2'd0;
        endcase
    end

    assign o_value = KEY_MAP[{w_row_idx, w_col_idx}];

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates the row drive, debounces a press on the frozen row,
// strobes the decoded key once, then waits for a debounced release before rescanning.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] columns,
    output logic [3:0] row,
    output logic       key_pressed,
    output logic [3:0] value
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    logic [3:0]       r_row;
    logic [3:0]       r_cand;
    logic [CNT_W-1:0] r_count;
    logic [3:0]       r_value;
    logic             r_key_pressed;

    state_t           w_state_nxt;
    logic [3:0]       w_row_nxt;
    logic [3:0]       w_cand_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [3:0]       w_value_nxt;
    logic             w_key_pressed_nxt;
    logic [CNT_W-1:0] w_count_inc;
    logic [3:0]       w_decoded;

    // Acceptance only happens while columns match the frozen candidate, so decoding live columns is safe.
    keypad_decoder u_decoder (
        .i_row     (r_row),
        .i_columns (columns),
        .o_value   (w_decoded)
    );

    assign w_count_inc = r_count + CNT_ONE;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_SCAN;
            r_row         <= ROW_TOP;
            r_cand        <= 4'h0;
            r_count       <= '0;
            r_value       <= 4'h0;
            r_key_pressed <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_row         <= w_row_nxt;
            r_cand        <= w_cand_nxt;
            r_count       <= w_count_nxt;
            r_value       <= w_value_nxt;
            r_key_pressed <= w_key_pressed_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_row_nxt         = r_row;
        w_cand_nxt        = r_cand;
        w_count_nxt       = r_count;
        w_value_nxt       = r_value;
        w_key_pressed_nxt = 1'b0;

        case (r_state)
            ST_SCAN: begin
                if (columns != 4'h0) begin
                    w_cand_nxt = columns;
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_value_nxt       = w_decoded;
                        w_key_pressed_nxt = 1'b1;
                        w_count_nxt       = '0;
                        w_state_nxt       = ST_HELD;
                    end else begin
                        w_count_nxt = CNT_ONE;
                        w_state_nxt = ST_DEBOUNCE;
                    end
                end else begin
                    w_row_nxt = rotate_row(r_row);
                end
            end

            ST_DEBOUNCE: begin
                if (columns == r_cand) begin
                    if (w_count_inc == CNT_MAX) begin
                        w_value_nxt       = w_decoded;
                        w_key_pressed_nxt = 1'b1;
                        w_count_nxt       = '0;
                        w_state_nxt       = ST_HELD;
                    end else begin
                        w_count_nxt = w_count_inc;
                    end
                end else begin
                    // A bounce abandons the candidate and moves on to the next row.
                    w_count_nxt = '0;
                    w_row_nxt   = rotate_row(r_row);
                    w_state_nxt = ST_SCAN;
                end
            end

            ST_HELD: begin
                if (columns == 4'h0) begin
                    if (w_count_inc == CNT_MAX) begin
                        w_count_nxt = '0;
                        w_state_nxt = ST_SCAN;
                    end else begin
                        w_count_nxt = w_count_inc;
                    end
                end else begin
                    w_count_nxt = '0;
                end
            end

            default: begin
                w_count_nxt = '0;
                w_row_nxt   = ROW_TOP;
                w_state_nxt = ST_SCAN;
            end
        endcase
    end

    assign row         = r_row;
    assign key_pressed = r_key_pressed;
    assign value       = r_value;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: stimulus pushes expected key codes into a
// scoreboard queue and a separate monitor pops and compares on every strobe.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] columns;
    logic [3:0] row;
    logic       key_pressed;
    logic [3:0] value;

    logic [3:0] columns1;
    logic [3:0] row1;
    logic       key_pressed1;
    logic [3:0] value1;

    int         checks = 0;
    int         errors = 0;
    int         strobe_cnt = 0;
    logic [3:0] sb [$];

    keypad_scanner #(.DEBOUNCE_CYCLES(4)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .columns     (columns),
        .row         (row),
        .key_pressed (key_pressed),
        .value       (value)
    );

    keypad_scanner #(.DEBOUNCE_CYCLES(1)) u_dut1 (
        .clk         (clk),
        .reset       (reset),
        .columns     (columns1),
        .row         (row1),
        .key_pressed (key_pressed1),
        .value       (value1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_row(input logic [3:0] target);
        int n = 0;
        while (row !== target && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("wait_row", row, target);
    endtask

    // Press, then count negedges until the strobe; expected latency is DEBOUNCE_CYCLES.
    task automatic press(input logic [3:0] cols, input logic [3:0] exp_val, input logic [3:0] frozen);
        int k = 0;
        columns = cols;
        sb.push_back(exp_val);
        do begin
            @(negedge clk);
            k++;
        end while (!key_pressed && k < 10);
        check("press_latency", k, 4);
        check("row_frozen", row, frozen);
    endtask

    task automatic release_key(input logic [3:0] frozen);
        columns = 4'h0;
        repeat (4) @(negedge clk);
        check("release_row_held", row, frozen);
        @(negedge clk);
        check("release_row_resumed", row, {frozen[0], frozen[3:1]});
    endtask

    // Monitor: every strobe must match the oldest pending expectation.
    initial begin
        logic       prev = 1'b0;
        logic [3:0] exp_val;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b0;
            end else begin
                if (key_pressed) begin
                    strobe_cnt++;
                    check("single_cycle_strobe", prev, 0);
                    if (sb.size() == 0) begin
                        check("strobe_expected", sb.size(), 1);
                    end else begin
                        exp_val = sb.pop_front();
                        check("strobe_value", value, exp_val);
                    end
                end
                prev = key_pressed;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] rot [4];
        int s0;
        int n;
        rot[0] = 4'b1000; rot[1] = 4'b0100; rot[2] = 4'b0010; rot[3] = 4'b0001;
        reset    = 1'b1;
        columns  = 4'h0;
        columns1 = 4'h0;
        repeat (3) @(negedge clk);
        check("reset_row", row, 4'b1000);
        check("reset_key_pressed", key_pressed, 0);
        check("reset_value", value, 4'h0);
        reset = 1'b0;

        // Idle rotation
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("scan_rotation", row, rot[i % 4]);
        end

        // Key A on the top row
        wait_row(4'b1000);
        press(4'b1000, 4'hA, 4'b1000);
        repeat (3) @(negedge clk);
        check("held_row_frozen", row, 4'b1000);
        release_key(4'b1000);

        // Bounce: two cycles on row 0010, then released
        wait_row(4'b0010);
        columns = 4'b0001;
        @(negedge clk);
        check("bounce_row_frozen", row, 4'b0010);
        @(negedge clk);
        columns = 4'h0;
        @(negedge clk);
        check("bounce_rotation_resumes", row, 4'b0001);
        repeat (3) @(negedge clk);
        check("bounce_value_unchanged", value, 4'hA);

        // Key 5 held for 20 cycles: exactly one strobe
        wait_row(4'b0100);
        s0 = strobe_cnt;
        columns = 4'b0010;
        sb.push_back(4'h5);
        repeat (20) @(negedge clk);
        check("hold_single_strobe", strobe_cnt - s0, 1);
        check("hold_value", value, 4'h5);
        release_key(4'b0100);

        // Two columns on the bottom row: highest column wins
        wait_row(4'b0001);
        press(4'b1001, 4'hD, 4'b0001);
        release_key(4'b0001);

        // Reset mid-debounce abandons the key
        wait_row(4'b1000);
        columns = 4'b0100;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset_row", row, 4'b1000);
        check("midreset_key_pressed", key_pressed, 0);
        check("midreset_value", value, 4'h0);
        columns = 4'h0;
        @(negedge clk);
        reset = 1'b0;
        s0 = strobe_cnt;
        repeat (10) @(negedge clk);
        check("midreset_no_strobe", strobe_cnt - s0, 0);

        // DEBOUNCE_CYCLES=1: accepted on the detection edge
        n = 0;
        while (row1 !== 4'b0100 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("dc1_wait_row", row1, 4'b0100);
        columns1 = 4'b0001;
        @(negedge clk);
        check("dc1_strobe", key_pressed1, 1);
        check("dc1_value", value1, 4'h4);
        check("dc1_row_frozen", row1, 4'b0100);
        @(negedge clk);
        check("dc1_strobe_one_cycle", key_pressed1, 0);
        columns1 = 4'h0;

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
